// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder: accepts a 32-bit unsigned value over valid/ready and
// converts it to 8 packed BCD digits with a sequential double-dabble loop.
// The result is held on a stable output register that only updates on commit.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   in_valid  in_value offered this cycle
//   in_ready  idle and able to accept (registered)
//   in_value  unsigned binary value to convert
//   bcd_out   packed BCD result, digit 0 in [3:0]; all 'E' on overflow
//   ovf       last committed value exceeded 99_999_999
//   done      one-cycle pulse when bcd_out/ovf update
module bcd_display_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic [31:0] bcd_out,
  output logic        ovf,
  output logic        done
);

  localparam int unsigned W      = 32;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned CNT_W  = 5;

  localparam logic [W-1:0]     MAX_VAL   = W'(99_999_999);
  localparam logic [W-1:0]     ERR_WORD  = 32'hEEEE_EEEE;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_p_q, ovf_p_d;
  logic [W-1:0]     bcd_out_q, bcd_out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;

  logic [W-1:0]     acc_fix;

  // Double-dabble digit correction: a digit >= 5 would carry past 9 after the shift.
  function automatic logic [3:0] fix_nib(input logic [3:0] n);
    fix_nib = (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // All eight digits are corrected in parallel on the pre-shift accumulator.
  always_comb begin
    acc_fix = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      acc_fix[i*4 +: 4] = fix_nib(acc_q[i*4 +: 4]);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_p_d    = ovf_p_q;
    bcd_out_d  = bcd_out_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    in_ready_d = in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          bin_d      = in_value;
          acc_d      = '0;
          ovf_p_d    = (in_value > MAX_VAL);
          cnt_d      = CNT_START;
          in_ready_d = 1'b0;
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Top bit of the corrected accumulator falls off; only overflow values reach it.
        acc_d = W'({acc_fix, bin_q[W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        bcd_out_d  = ovf_p_q ? ERR_WORD : acc_q;
        ovf_d      = ovf_p_q;
        done_d     = 1'b1;
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_p_q    <= 1'b0;
      bcd_out_q  <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_p_q    <= ovf_p_d;
      bcd_out_q  <= bcd_out_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign bcd_out  = bcd_out_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: a cycle-level behavioural model
// (decimal arithmetic plus a countdown to commit) is compared against the DUT
// outputs on every negedge, with literal checks at the key points.
module tb_bcd_display_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [31:0] bcd_out;
  logic        ovf;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_display_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .bcd_out  (bcd_out),
    .ovf      (ovf),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [31:0] to_bcd(input logic [31:0] v);
    logic [31:0] x;
    logic [31:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] expect_word(input logic [31:0] v);
    return (v > 32'd99_999_999) ? 32'hEEEE_EEEE : to_bcd(v);
  endfunction

  // Behavioural model: accept when idle, commit 33 edges later.
  logic [31:0] m_bcd, m_val;
  logic        m_ovf, m_done, m_ready;
  int          m_left = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_bcd   = '0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
      m_ready = 1'b1;
      m_left  = 0;
      chk_en  = 1;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ovf   = (m_val > 32'd99_999_999);
          m_bcd   = expect_word(m_val);
          m_done  = 1'b1;
          m_ready = 1'b1;
        end
      end else if (m_ready && in_valid) begin
        m_val   = in_value;
        m_left  = 33;
        m_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_bcd_out", bcd_out, m_bcd);
      check("model_ovf", 32'(ovf), 32'(m_ovf));
      check("model_done", 32'(done), 32'(m_done));
      check("model_in_ready", 32'(in_ready), 32'(m_ready));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic start(input logic [31:0] v);
    wait_ready();
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_value = $urandom;
  endtask

  task automatic finish(input logic [31:0] exp, input logic exp_ovf, input int exp_lat);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("commit_latency", 32'(n), 32'(exp_lat));
    check("bcd_literal", bcd_out, exp);
    check("ovf_literal", 32'(ovf), 32'(exp_ovf));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic convert(input logic [31:0] v, input logic [31:0] exp, input logic exp_ovf);
    start(v);
    finish(exp, exp_ovf, 33);
  endtask

  initial begin
    int k, last, n, dcount;
    logic [31:0] v;

    // Model pins
    check("pin_to_bcd", to_bcd(32'd12_345_678), 32'h1234_5678);
    check("pin_to_bcd_max", to_bcd(32'd99_999_999), 32'h9999_9999);
    check("pin_expect_ovf", expect_word(32'd100_000_000), 32'hEEEE_EEEE);

    // Reset with in_valid high
    rst = 1'b1;
    in_valid = 1'b1;
    in_value = 32'd12345;
    repeat (2) @(negedge clk);
    check("rst_bcd", bcd_out, 32'h0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_no_accept", 32'(in_ready), 32'd1);

    // Nominal and boundary
    convert(32'd12_345_678, 32'h1234_5678, 1'b0);
    convert(32'd0, 32'h0000_0000, 1'b0);
    convert(32'd99_999_999, 32'h9999_9999, 1'b0);
    convert(32'd100_000_000, 32'hEEEE_EEEE, 1'b1);
    convert(32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1);
    convert(32'd7, 32'h0000_0007, 1'b0);

    // Output stability while shifting, with noisy inputs
    convert(32'd42, 32'h0000_0042, 1'b0);
    start(32'd7);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      check("stable_bcd", bcd_out, 32'h0000_0042);
      if (done === 1'b1) dcount++;
      in_value = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stable_no_early_done", 32'(dcount), 32'd0);
    finish(32'h0000_0007, 1'b0, 3);

    // Back-to-back with in_valid held high
    k = 0;
    last = -1;
    n = 0;
    in_valid = 1'b1;
    while (n < 21 * 34 + 100) begin
      if (in_ready === 1'b1) begin
        if (k == 21) break;
        if (last >= 0) check("accept_spacing", 32'(cyc - last), 32'd34);
        last = cyc;
        in_value = 32'(k);
        k++;
      end
      if (done === 1'b1) check("b2b_bcd", bcd_out, to_bcd(32'(k - 2)));
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(k), 32'd21);
    check("b2b_last", bcd_out, 32'h0000_0020);

    // Reset during SHIFT
    start(32'd55_555_555);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_bcd", bcd_out, 32'h0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("midrst_no_done", 32'(dcount), 32'd0);
    convert(32'd31_415_926, 32'h3141_5926, 1'b0);

    // Randomized values, mixing in-range and overflow
    for (int i = 0; i < 12; i++) begin
      v = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 99_999_999));
      convert(v, expect_word(v), v > 32'd99_999_999);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_feeder.md
# bcd_display_feeder

Upstream stage for the 8-digit seven-segment scanner. It accepts a 32-bit unsigned binary value through a valid/ready handshake and converts it to 8 packed BCD digits using a sequential double-dabble (shift-add-3) loop. It presents the result on a stable, double-buffered 32-bit output that drives the scanner's `data` input directly. The output never shows intermediate conversion state; out-of-range values display as all "E".

## Interface

- Parameters: none. Input width is fixed at 32 bits; output is fixed at 8 BCD digits.
- `clk` in 1: system clock. All logic is on `posedge clk`.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_value` is offered this cycle.
- `in_ready` out 1: block is idle and will accept on this edge if `in_valid` is high.
- `in_value` in 32: unsigned binary value to display.
- `bcd_out` out 32: packed BCD. Digit 0 (least significant) is in [3:0]; digit 7 is in [31:28]. Connects to the scanner `data` input.
- `ovf` out 1: the last committed value exceeded 99_999_999.
- `done` out 1: one-cycle pulse when `bcd_out`/`ovf` are updated.

## Operation

- States: IDLE, SHIFT, COMMIT.
- IDLE
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`:
    - capture `in_value` into a 32-bit shift register `bin`;
    - clear the 32-bit accumulator `acc`;
    - latch `ovf_p` = (`in_value` > 32'd99_999_999);
    - load `cnt` = 31;
    - go to SHIFT.
- SHIFT (exactly 32 cycles)
  - Each cycle, first correct `acc`: every nibble ≥ 5 gets +3, computed in parallel on the pre-shift value.
  - Then `acc` <= {corrected_acc[30:0], `bin`[31]} and `bin` <= `bin` << 1.
  - `cnt` decrements. On the cycle with `cnt` == 0, go to COMMIT.
  - Overflow values run the full loop. Latency is constant; the bits that fall off the top of `acc` are discarded.
- COMMIT (1 cycle)
  - `bcd_out` <= `ovf_p` ? 32'hEEEE_EEEE : `acc`.
  - `ovf` <= `ovf_p`.
  - `done` <= 1.
  - Go to IDLE.
- `bcd_out` and `ovf` change only on the COMMIT edge or on reset. They hold their previous value throughout SHIFT.
- `in_valid` outside IDLE is ignored. There is no queuing; the upstream agent must hold or re-present the value.
- `in_value` is sampled only on the accept edge. Later changes have no effect on the conversion in progress.
- Boundary values:
  - `in_value` = 0 commits 32'h0000_0000.
  - `in_value` = 99_999_999 commits 32'h9999_9999 with `ovf` = 0.
  - `in_value` = 100_000_000 or more commits 32'hEEEE_EEEE with `ovf` = 1.

## Timing

- Reset values (sync, on the edge where `rst` = 1):
  - state IDLE, `in_ready` = 1, `bcd_out` = 32'h0, `ovf` = 0, `done` = 0;
  - `acc`, `bin`, `cnt` cleared.
- `rst` has priority over all other inputs, including during SHIFT or COMMIT. An in-flight conversion is discarded with no `done` pulse.
- `in_ready` is registered. It goes low in the cycle after the accept edge E.
- Accept edge E, then SHIFT edges E+1..E+32, then COMMIT edge E+33.
  - New `bcd_out`/`ovf` and `done` = 1 are visible in cycle E+33..E+34.
  - `done` is high for exactly one cycle.
- `in_ready` returns to 1 in the same cycle that `done` is high. The next accept can occur at edge E+34, giving a throughput of one conversion per 34 cycles.
- Combinational depth per cycle: eight parallel 4-bit compare/add-3 stages plus a shift. No multi-cycle paths.

## Test plan

- Reset:
  - Stimulus: hold `rst` for 2 cycles with `in_valid` = 1.
  - Required: `bcd_out` = 0, `ovf` = 0, `done` = 0, `in_ready` = 1, and no accept occurs.
- Nominal conversion:
  - Stimulus: accept `in_value` = 12_345_678.
  - Required: `done` pulses for 1 cycle after edge E+33; `bcd_out` = 32'h1234_5678; `ovf` = 0.
  - Repeat with 0 (expect 32'h0) and 99_999_999 (expect 32'h9999_9999).
- Overflow:
  - Stimulus: `in_value` = 100_000_000, then 32'hFFFF_FFFF.
  - Required: `bcd_out` = 32'hEEEE_EEEE and `ovf` = 1 for both.
  - Then convert 7. Required: `bcd_out` = 32'h0000_0007 and `ovf` = 0.
- Output stability:
  - Stimulus: after committing 42, accept 7. During SHIFT, toggle `in_value` randomly and pulse `in_valid`.
  - Required: `bcd_out` = 32'h0000_0042 every cycle until edge E+33, then 32'h0000_0007. Only one `done` pulse occurs.
- Back-to-back:
  - Stimulus: `in_valid` held high with an incrementing `in_value` 0..20.
  - Required: accepts occur exactly every 34 cycles. Each committed `bcd_out` equals the decimal-to-BCD encoding of its value.
- Reset mid-operation:
  - Stimulus: assert `rst` at SHIFT cycle 10 of converting 55_555_555.
  - Required: next cycle `bcd_out` = 0, `in_ready` = 1, and no `done` pulse. A subsequent conversion of 31_415_926 commits 32'h3141_5926.
